// File: rtl/ahb_lite_pkg.sv
// AHB-Lite encodings and DMA master state type shared by the DMA block and its bench.
package ahb_lite_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_ADDR = 3'd1,
      S_RD_DATA = 3'd2,
      S_WR_ADDR = 3'd3,
      S_WR_DATA = 3'd4,
      S_FINISH  = 3'd5
   } dma_state_t;

endpackage

// File: rtl/ahb_dma_master.sv
// Single-channel AHB-Lite DMA master: copies a block of words, one
// non-pipelined transfer at a time (read source word, then write it out).
module ahb_dma_master
   import ahb_lite_pkg::*;
#(
   parameter int unsigned COUNT_W   = 16,
   parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
   input  logic               HCLK,
   input  logic               HRESET,
   input  logic               Start,
   input  logic [31:0]        SrcAddr,
   input  logic [31:0]        DstAddr,
   input  logic [COUNT_W-1:0] WordCount,
   output logic               Busy,
   output logic               Done,
   output logic               Err,
   output logic [31:0]        HADDR,
   output logic [1:0]         HTRANS,
   output logic               HWRITE,
   output logic [2:0]         HSIZE,
   output logic [2:0]         HBURST,
   output logic [3:0]         HPROT,
   output logic               HMASTLOCK,
   output logic [31:0]        HWDATA,
   input  logic [31:0]        HRDATA,
   input  logic               HREADY,
   input  logic               HRESP
);

   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
   localparam logic [31:0] WORD_STEP = 32'd4;

   dma_state_t         r_state, w_next;
   logic [31:0]        r_src, r_dst, w_src_nxt, w_dst_nxt;
   logic [COUNT_W-1:0] r_count, w_count_nxt;
   logic [31:0]        r_buf;
   logic [31:0]        r_haddr;
   htrans_t            r_htrans;
   logic               r_hwrite;
   logic               r_busy, r_done, r_err;
   logic               w_start_acc, w_err_set, w_capture;

   // Next state plus next source/destination/count values for the copy loop.
   always_comb begin
      w_next      = r_state;
      w_src_nxt   = r_src;
      w_dst_nxt   = r_dst;
      w_count_nxt = r_count;
      w_start_acc = 1'b0;
      w_err_set   = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Start) begin
               w_start_acc = 1'b1;
               w_src_nxt   = SrcAddr & WORD_MASK;
               w_dst_nxt   = DstAddr & WORD_MASK;
               w_count_nxt = WordCount;
               w_next      = (WordCount == COUNT_W'(0)) ? S_FINISH : S_RD_ADDR;
            end
         end
         S_RD_ADDR: begin
            if (HREADY) w_next = S_RD_DATA;
         end
         S_RD_DATA: begin
            if (HRESP) begin
               w_err_set = 1'b1;
               w_next    = S_IDLE;
            end else if (HREADY) begin
               w_capture = 1'b1;
               w_next    = S_WR_ADDR;
            end
         end
         S_WR_ADDR: begin
            if (HREADY) w_next = S_WR_DATA;
         end
         S_WR_DATA: begin
            if (HRESP) begin
               w_err_set = 1'b1;
               w_next    = S_IDLE;
            end else if (HREADY) begin
               w_src_nxt   = r_src + WORD_STEP;
               w_dst_nxt   = r_dst + WORD_STEP;
               w_count_nxt = r_count - COUNT_W'(1);
               w_next      = (r_count == COUNT_W'(1)) ? S_FINISH : S_RD_ADDR;
            end
         end
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // State, datapath and registered bus/status outputs, all decoded from the next state.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state  <= S_IDLE;
         r_src    <= '0;
         r_dst    <= '0;
         r_count  <= '0;
         r_buf    <= '0;
         r_haddr  <= '0;
         r_htrans <= IDLE;
         r_hwrite <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_src   <= w_src_nxt;
         r_dst   <= w_dst_nxt;
         r_count <= w_count_nxt;
         if (w_capture) r_buf <= HRDATA;
         r_htrans <= (w_next == S_RD_ADDR || w_next == S_WR_ADDR) ? NONSEQ : IDLE;
         if (w_next == S_RD_ADDR) begin
            r_haddr  <= w_src_nxt;
            r_hwrite <= 1'b0;
         end else if (w_next == S_WR_ADDR) begin
            r_haddr  <= w_dst_nxt;
            r_hwrite <= 1'b1;
         end
         r_busy <= (w_next == S_RD_ADDR) || (w_next == S_RD_DATA) ||
                   (w_next == S_WR_ADDR) || (w_next == S_WR_DATA);
         r_done <= (w_next == S_FINISH);
         if (w_start_acc)    r_err <= 1'b0;
         else if (w_err_set) r_err <= 1'b1;
      end
   end

   assign Busy      = r_busy;
   assign Done      = r_done;
   assign Err       = r_err;
   assign HADDR     = r_haddr;
   assign HTRANS    = r_htrans;
   assign HWRITE    = r_hwrite;
   assign HWDATA    = r_buf;
   assign HSIZE     = HSIZE_WORD;
   assign HBURST    = HBURST_SINGLE;
   assign HPROT     = HPROT_VAL;
   assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_dma_master.sv
// Bench for ahb_dma_master: simple AHB-Lite RAM slave with programmable wait
// states and error injection, a transaction-level copy model, table-driven
// and random copies, plus hand-written restart/reset sequences.
`timescale 1ns/1ps
module tb_ahb_dma_master;
   import ahb_lite_pkg::*;

   localparam int unsigned COUNT_W = 16;
   localparam int          BUDGET  = 400;

   logic               HCLK = 1'b0;
   logic               HRESET, Start;
   logic [31:0]        SrcAddr, DstAddr;
   logic [COUNT_W-1:0] WordCount;
   logic               Busy, Done, Err;
   logic [31:0]        HADDR, HWDATA, HRDATA;
   logic [1:0]         HTRANS;
   logic               HWRITE, HMASTLOCK, HREADY, HRESP;
   logic [2:0]         HSIZE, HBURST;
   logic [3:0]         HPROT;

   ahb_dma_master #(.COUNT_W(COUNT_W), .HPROT_VAL(4'b0011)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .Start(Start), .SrcAddr(SrcAddr), .DstAddr(DstAddr),
      .WordCount(WordCount), .Busy(Busy), .Done(Done), .Err(Err), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
      .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   always #5 HCLK = ~HCLK;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- slave: 1K-word RAM window, wait states, error injection
   logic [31:0]  mem [0:1023];
   int unsigned  wait_n = 0;
   logic         err_en = 1'b0;
   logic [31:0]  err_addr = '0;
   logic         dp_valid = 1'b0, dp_write = 1'b0, err_ph = 1'b0;
   logic [31:0]  dp_addr = '0, sl_rdata = '0;
   int unsigned  stall = 0;
   logic [32:0]  tr_q [$];   // accepted address phases {write, addr}
   logic [63:0]  wr_q [$];   // completed writes {addr, data}

   assign HRDATA = sl_rdata;

   always_comb begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      if (dp_valid && err_en && dp_addr == err_addr) begin
         HRESP  = 1'b1;
         HREADY = err_ph;
      end else if ((dp_valid || HTRANS == 2'b10) && stall < wait_n) begin
         HREADY = 1'b0;
      end
   end

   always @(posedge HCLK) begin
      if (HRESET) begin
         dp_valid <= 1'b0;
         stall    <= 0;
         err_ph   <= 1'b0;
      end else begin
         stall <= HREADY ? 0 : stall + 1;
         if (dp_valid && err_en && dp_addr == err_addr) err_ph <= ~err_ph;
         if (dp_valid && HREADY) begin
            if (dp_write && !HRESP) wr_q.push_back({dp_addr, HWDATA});
            dp_valid <= 1'b0;
            err_ph   <= 1'b0;
         end
         if (HTRANS == 2'b10 && HREADY) begin
            dp_valid <= 1'b1;
            dp_addr  <= HADDR;
            dp_write <= HWRITE;
            sl_rdata <= mem[HADDR[11:2]];
            tr_q.push_back({HWRITE, HADDR});
         end
      end
   end

   // ---------------- stall-stability monitor
   int          stab_err = 0;
   logic        pv = 1'b0, p_hready = 1'b1, p_hresp = 1'b0, p_hwrite = 1'b0, p_wdp = 1'b0;
   logic [1:0]  p_htrans = '0;
   logic [31:0] p_haddr = '0, p_hwdata = '0;

   always @(posedge HCLK) begin
      if (pv && !HRESET && !p_hready && !p_hresp) begin
         if (p_htrans == 2'b10 && (HTRANS != p_htrans || HADDR != p_haddr || HWRITE != p_hwrite))
            stab_err <= stab_err + 1;
         else if (p_wdp && HWDATA != p_hwdata)
            stab_err <= stab_err + 1;
      end
      pv       <= !HRESET;
      p_hready <= HREADY;
      p_hresp  <= HRESP;
      p_htrans <= HTRANS;
      p_haddr  <= HADDR;
      p_hwrite <= HWRITE;
      p_hwdata <= HWDATA;
      p_wdp    <= dp_valid && dp_write;
   end

   // ---------------- copy records and transaction-level model
   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      int          n;
      int          w;
      bit          err_en;
      logic [31:0] err_addr;
      bit          exp_err;
      int          exp_lat;   // cycles from Start edge to Done (0 = no Done)
      int          exp_ntr;   // address phases issued
   } rec_t;

   logic [32:0] exp_tr [$];
   logic [63:0] exp_wr [$];
   bit          m_err;
   int          m_lat;

   // A copy is n read/write pairs of consecutive words; it stops at the first
   // errored phase. Each phase lasts w+1 cycles, plus one FINISH cycle.
   task automatic model(input rec_t r);
      logic [31:0] s, d, ra, wa;
      exp_tr.delete();
      exp_wr.delete();
      m_err = 1'b0;
      s = r.src & 32'hFFFF_FFFC;
      d = r.dst & 32'hFFFF_FFFC;
      for (int k = 0; k < r.n && !m_err; k++) begin
         ra = s + 32'(4 * k);
         wa = d + 32'(4 * k);
         exp_tr.push_back({1'b0, ra});
         if (r.err_en && ra == r.err_addr) begin
            m_err = 1'b1;
         end else begin
            exp_tr.push_back({1'b1, wa});
            if (r.err_en && wa == r.err_addr) m_err = 1'b1;
            else exp_wr.push_back({wa, mem[ra[11:2]]});
         end
      end
      m_lat = m_err ? 0 : 4 * r.n * (r.w + 1) + 1;
   endtask

   task automatic preload(input rec_t r);
      logic [31:0] a;
      for (int k = 0; k < r.n; k++) begin
         a = (r.src & 32'hFFFF_FFFC) + 32'(4 * k);
         mem[a[11:2]] = $urandom;
      end
   endtask

   // Runs one copy starting at a negedge and compares it with the model.
   task automatic run_copy(input string tag, input rec_t r, input bit use_exp);
      int  lat = 0, done_cnt = 0, s0;
      bit  busy_seen = 0, fin = 0;
      preload(r);
      model(r);
      if (use_exp) begin
         check({tag, "_model_err"}, 64'(m_err), 64'(r.exp_err));
         check({tag, "_model_lat"}, 64'(m_lat), 64'(r.exp_lat));
         check({tag, "_model_ntr"}, 64'(exp_tr.size()), 64'(r.exp_ntr));
      end
      tr_q.delete();
      wr_q.delete();
      wait_n   = r.w;
      err_en   = r.err_en;
      err_addr = r.err_addr;
      s0       = stab_err;
      SrcAddr = r.src; DstAddr = r.dst; WordCount = COUNT_W'(r.n); Start = 1'b1;
      for (int c = 1; c <= BUDGET && !fin; c++) begin
         @(posedge HCLK);
         @(negedge HCLK);
         if (c == 1) begin
            Start = 1'b0;
            check({tag, "_err_cleared"}, 64'(Err), 64'(0));
         end
         if (Busy) busy_seen = 1;
         if (Done) begin
            done_cnt++;
            if (lat == 0) lat = c;
         end
         if (c > 1 && !Busy && !Done) fin = 1;
      end
      check({tag, "_terminated"}, 64'(fin), 64'(1));
      repeat (3) @(negedge HCLK);
      check({tag, "_err"}, 64'(Err), 64'(m_err));
      check({tag, "_done_pulses"}, 64'(done_cnt), 64'(m_err ? 0 : 1));
      check({tag, "_latency"}, 64'(lat), 64'(m_lat));
      check({tag, "_busy_seen"}, 64'(busy_seen), 64'(r.n > 0));
      check({tag, "_busy_end"}, 64'(Busy), 64'(0));
      check({tag, "_ntr"}, 64'(tr_q.size()), 64'(exp_tr.size()));
      check({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_wr.size()));
      begin
         int bad = 0;
         for (int i = 0; i < tr_q.size() && i < exp_tr.size(); i++)
            if (tr_q[i] !== exp_tr[i]) bad++;
         for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
            if (wr_q[i] !== exp_wr[i]) bad++;
         check({tag, "_seq_mismatches"}, 64'(bad), 64'(0));
      end
      check({tag, "_stall_stable"}, 64'(stab_err - s0), 64'(0));
   endtask

   rec_t tbl [8];

   initial begin
      HRESET = 1'b1; Start = 1'b0; SrcAddr = '0; DstAddr = '0; WordCount = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 | 32'(i);

      // reset state after two cycles of HRESET
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      check("rst_htrans", 64'(HTRANS), 64'(0));
      check("rst_busy",   64'(Busy),   64'(0));
      check("rst_done",   64'(Done),   64'(0));
      check("rst_err",    64'(Err),    64'(0));
      check("rst_haddr",  64'(HADDR),  64'(0));
      check("rst_hwrite", 64'(HWRITE), 64'(0));
      check("rst_hwdata", 64'(HWDATA), 64'(0));
      check("const_hsize",  64'(HSIZE),  64'(3'b010));
      check("const_hburst", 64'(HBURST), 64'(3'b000));
      check("const_hprot",  64'(HPROT),  64'(4'b0011));
      check("const_lock",   64'(HMASTLOCK), 64'(0));
      HRESET = 1'b0;
      @(negedge HCLK);

      //            src            dst            n  w  err  err_addr      e_err lat ntr
      tbl[0] = '{32'h0000_0100, 32'h0000_0200, 3, 0, 0, 32'h0,          0, 13, 6};
      tbl[1] = '{32'h0000_0100, 32'h0000_0200, 3, 2, 0, 32'h0,          0, 37, 6};
      tbl[2] = '{32'h0000_0100, 32'h0000_0200, 0, 0, 0, 32'h0,          0,  1, 0};
      tbl[3] = '{32'h0000_0100, 32'h0000_0200, 3, 0, 1, 32'h0000_0104,  1,  0, 3};
      tbl[4] = '{32'h0000_0100, 32'h0000_0200, 3, 1, 1, 32'h0000_0208,  1,  0, 6};
      tbl[5] = '{32'hFFFF_FFF8, 32'h0000_0300, 3, 0, 0, 32'h0,          0, 13, 6};
      tbl[6] = '{32'h0000_0040, 32'hFFFF_FFFC, 2, 1, 0, 32'h0,          0, 17, 4};
      tbl[7] = '{32'h0000_0102, 32'h0000_0201, 1, 0, 0, 32'h0,          0,  5, 2};
      for (int i = 0; i < 8; i++) run_copy($sformatf("tbl%0d", i), tbl[i], 1'b1);

      // Err stays set after an aborted copy until the next Start
      begin
         rec_t e = '{32'h0000_0180, 32'h0000_0280, 2, 0, 1, 32'h0000_0180, 1, 0, 1};
         run_copy("sticky", e, 1'b1);
         repeat (5) @(negedge HCLK);
         check("sticky_err_held", 64'(Err), 64'(1));
      end

      // randomized copies against the model
      for (int t = 0; t < 24; t++) begin
         rec_t r;
         r.src = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 250)) << 2) | 32'($urandom_range(0, 3));
         r.dst = ($urandom & 32'hFFFF_F000) | 32'h800 | (32'($urandom_range(0, 250)) << 2);
         r.n   = $urandom_range(0, 5);
         r.w   = $urandom_range(0, 2);
         r.err_en = ($urandom_range(0, 2) == 0) && r.n > 0;
         r.err_addr = ($urandom_range(0, 1) == 0 ? (r.src & 32'hFFFF_FFFC) : r.dst) +
                      32'(4 * $urandom_range(0, r.n > 0 ? r.n - 1 : 0));
         r.exp_err = 0; r.exp_lat = 0; r.exp_ntr = 0;
         run_copy($sformatf("rnd%0d", t), r, 1'b0);
      end

      // Start while busy is ignored; HRESET mid-copy returns to reset state for good
      begin
         rec_t a = '{32'h0000_0100, 32'h0000_0200, 4, 0, 0, 32'h0, 0, 17, 8};
         int   bad = 0, ntr, dn = 0;
         preload(a);
         model(a);
         tr_q.delete();
         wr_q.delete();
         wait_n = 0; err_en = 1'b0;
         SrcAddr = a.src; DstAddr = a.dst; WordCount = COUNT_W'(a.n); Start = 1'b1;
         @(negedge HCLK); Start = 1'b0;
         repeat (2) @(negedge HCLK);
         SrcAddr = 32'h0000_0380; DstAddr = 32'h0000_03C0; WordCount = COUNT_W'(1); Start = 1'b1;
         @(negedge HCLK); Start = 1'b0;
         repeat (2) @(negedge HCLK);
         check("restart_busy", 64'(Busy), 64'(1));
         check("restart_ntr_nonzero", 64'(tr_q.size() > 0), 64'(1));
         for (int i = 0; i < tr_q.size() && i < exp_tr.size(); i++)
            if (tr_q[i] !== exp_tr[i]) bad++;
         check("restart_ignored", 64'(bad), 64'(0));
         HRESET = 1'b1;
         @(negedge HCLK);
         HRESET = 1'b0;
         check("midrst_htrans", 64'(HTRANS), 64'(0));
         check("midrst_busy",   64'(Busy),   64'(0));
         check("midrst_done",   64'(Done),   64'(0));
         check("midrst_err",    64'(Err),    64'(0));
         check("midrst_haddr",  64'(HADDR),  64'(0));
         check("midrst_hwrite", 64'(HWRITE), 64'(0));
         check("midrst_hwdata", 64'(HWDATA), 64'(0));
         ntr = tr_q.size();
         for (int c = 0; c < 30; c++) begin
            @(negedge HCLK);
            if (Done || Busy) dn++;
         end
         check("midrst_no_transfers", 64'(tr_q.size()), 64'(ntr));
         check("midrst_no_done_busy", 64'(dn), 64'(0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
